rv_issue_q: RTL and testbench



---
 rtl/rv_iq_pkg.sv | 27 ++
 rtl/rv_iq_entry.sv | 96 +++++++++
 rtl/rv_issue_q.sv | 172 +++++++++++++++++
 tb/tb_rv_issue_q.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_iq_pkg.sv
// Shared types and helpers for the rv_issue_q reservation-station queue.
package rv_iq_pkg;

  // Default geometry of the queue.
  localparam int unsigned IQ_N_DEF      = 16;
  localparam int unsigned IQ_DAT_W_DEF  = 7;
  localparam int unsigned IQ_ITAG_W_DEF = 7;

  // Per-entry status bits. The itags and payload are kept as separate
  // vectors because their widths are module parameters.
  typedef struct packed {
    logic vld;
    logic rdy_a;
    logic rdy_b;
  } iq_flags_t;

  // Width of the occupancy counter. It must be able to hold the value n itself.
  function automatic int unsigned iq_cnt_w(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

  // Entry counts the queue is built for (8, 12 or 16).
  function automatic logic iq_legal_n(input int unsigned n);
    return (n == 32'd8) || (n == 32'd12) || (n == 32'd16);
  endfunction

endpackage

// File: rtl/rv_iq_entry.sv
// One reservation-station slot: registered state, itag wakeup comparators and
// the hold / load-new / load-from-upper-neighbour / clear next-state mux.
module rv_iq_entry
  import rv_iq_pkg::*;
#(
  parameter int unsigned q_dat_width_g  = IQ_DAT_W_DEF,
  parameter int unsigned q_itag_width_g = IQ_ITAG_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_b,
  input  logic                      flush_i,
  input  logic                      load_i,
  input  logic                      shift_i,
  input  logic                      wk_vld_i,
  input  logic [q_itag_width_g-1:0] wk_itag_i,
  input  iq_flags_t                 new_flg_i,
  input  logic [q_itag_width_g-1:0] new_itag_a_i,
  input  logic [q_itag_width_g-1:0] new_itag_b_i,
  input  logic [q_dat_width_g-1:0]  new_dat_i,
  input  iq_flags_t                 up_flg_i,
  input  logic [q_itag_width_g-1:0] up_itag_a_i,
  input  logic [q_itag_width_g-1:0] up_itag_b_i,
  input  logic [q_dat_width_g-1:0]  up_dat_i,
  output iq_flags_t                 wkn_flg_o,
  output logic [q_itag_width_g-1:0] itag_a_o,
  output logic [q_itag_width_g-1:0] itag_b_o,
  output logic [q_dat_width_g-1:0]  dat_o,
  output logic                      cond_o
);

  iq_flags_t                 flg_q, flg_d, wkn_flg_s;
  logic [q_itag_width_g-1:0] itag_a_q, itag_a_d;
  logic [q_itag_width_g-1:0] itag_b_q, itag_b_d;
  logic [q_dat_width_g-1:0]  dat_q, dat_d;

  // Current flags with this cycle's wakeup folded in. The lower neighbour uses
  // them on a shift so that a wakeup coinciding with the shift is not lost.
  always_comb begin
    wkn_flg_s       = flg_q;
    wkn_flg_s.rdy_a = flg_q.rdy_a | (flg_q.vld & wk_vld_i & (itag_a_q == wk_itag_i));
    wkn_flg_s.rdy_b = flg_q.rdy_b | (flg_q.vld & wk_vld_i & (itag_b_q == wk_itag_i));
  end

  // Next-state select. Flush beats load, and load beats shift, because the
  // allocation slot may be the one that the shift would otherwise refill.
  always_comb begin
    flg_d    = wkn_flg_s;
    itag_a_d = itag_a_q;
    itag_b_d = itag_b_q;
    dat_d    = dat_q;
    if (flush_i) begin
      flg_d    = '0;
      itag_a_d = '0;
      itag_b_d = '0;
      dat_d    = '0;
    end else if (load_i) begin
      flg_d    = new_flg_i;
      itag_a_d = new_itag_a_i;
      itag_b_d = new_itag_b_i;
      dat_d    = new_dat_i;
    end else if (shift_i) begin
      flg_d    = up_flg_i;
      itag_a_d = up_itag_a_i;
      itag_b_d = up_itag_b_i;
      dat_d    = up_dat_i;
    end else begin
      flg_d    = wkn_flg_s;
      itag_a_d = itag_a_q;
      itag_b_d = itag_b_q;
      dat_d    = dat_q;
    end
  end

  // Entry state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      flg_q    <= '0;
      itag_a_q <= '0;
      itag_b_q <= '0;
      dat_q    <= '0;
    end else begin
      flg_q    <= flg_d;
      itag_a_q <= itag_a_d;
      itag_b_q <= itag_b_d;
      dat_q    <= dat_d;
    end
  end

  assign wkn_flg_o = wkn_flg_s;
  assign itag_a_o  = itag_a_q;
  assign itag_b_o  = itag_b_q;
  assign dat_o     = dat_q;
  // Issue readiness is taken from registered state only.
  assign cond_o    = flg_q.vld & flg_q.rdy_a & flg_q.rdy_b;

endmodule

// File: rtl/rv_issue_q.sv
// Collapsing, age-ordered issue queue. Index 0 is always the oldest entry. Each
// cycle the oldest ready entry is moved into a registered valid/take issue
// stage and the entries above it slide down by one.
module rv_issue_q
  import rv_iq_pkg::*;
#(
  parameter int unsigned q_num_entries_g = IQ_N_DEF,
  parameter int unsigned q_dat_width_g   = IQ_DAT_W_DEF,
  parameter int unsigned q_itag_width_g  = IQ_ITAG_W_DEF
) (
  input  logic                                      clk,
  input  logic                                      rst_b,
  input  logic                                      flush,
  input  logic                                      in_vld,
  input  logic [q_itag_width_g-1:0]                 in_itag_a,
  input  logic [q_itag_width_g-1:0]                 in_itag_b,
  input  logic                                      in_rdy_a,
  input  logic                                      in_rdy_b,
  input  logic [q_dat_width_g-1:0]                  in_dat,
  output logic                                      in_full,
  input  logic                                      wk_vld,
  input  logic [q_itag_width_g-1:0]                 wk_itag,
  output logic                                      iss_vld,
  output logic [q_dat_width_g-1:0]                  iss_dat,
  input  logic                                      iss_take,
  output logic [iq_cnt_w(q_num_entries_g)-1:0]      q_cnt
);

  localparam int unsigned N  = q_num_entries_g;
  localparam int unsigned CW = iq_cnt_w(q_num_entries_g);

  // Per-entry views.
  iq_flags_t                 wkn_flg_s [N];
  logic [q_itag_width_g-1:0] itag_a_s  [N];
  logic [q_itag_width_g-1:0] itag_b_s  [N];
  logic [q_dat_width_g-1:0]  dat_s     [N];
  iq_flags_t                 up_flg_s  [N];
  logic [q_itag_width_g-1:0] up_itag_a_s [N];
  logic [q_itag_width_g-1:0] up_itag_b_s [N];
  logic [q_dat_width_g-1:0]  up_dat_s  [N];
  logic [N-1:0]              cond_s;
  logic [N-1:0]              mask_s;
  logic [N-1:0]              shift_s;
  logic [N-1:0]              load_s;

  // Control.
  logic                      any_rdy_s;
  logic [q_dat_width_g-1:0]  sel_dat_s;
  logic                      iss_en_s;
  logic                      alloc_s;
  logic [CW-1:0]             alloc_idx_s;
  iq_flags_t                 new_flg_s;

  // Registered state.
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      full_q, full_d;
  logic                      iss_vld_q, iss_vld_d;
  logic [q_dat_width_g-1:0]  iss_dat_q, iss_dat_d;

  // Entry array. The top slot refills from an empty slot when the queue collapses.
  for (genvar gi = 0; gi < N; gi++) begin : g_ent
    if (gi == N - 1) begin : g_top
      assign up_flg_s[gi]    = '0;
      assign up_itag_a_s[gi] = '0;
      assign up_itag_b_s[gi] = '0;
      assign up_dat_s[gi]    = '0;
    end else begin : g_mid
      assign up_flg_s[gi]    = wkn_flg_s[gi+1];
      assign up_itag_a_s[gi] = itag_a_s[gi+1];
      assign up_itag_b_s[gi] = itag_b_s[gi+1];
      assign up_dat_s[gi]    = dat_s[gi+1];
    end

    rv_iq_entry #(
      .q_dat_width_g  (q_dat_width_g),
      .q_itag_width_g (q_itag_width_g)
    ) u_ent (
      .clk          (clk),
      .rst_b        (rst_b),
      .flush_i      (flush),
      .load_i       (load_s[gi]),
      .shift_i      (shift_s[gi]),
      .wk_vld_i     (wk_vld),
      .wk_itag_i    (wk_itag),
      .new_flg_i    (new_flg_s),
      .new_itag_a_i (in_itag_a),
      .new_itag_b_i (in_itag_b),
      .new_dat_i    (in_dat),
      .up_flg_i     (up_flg_s[gi]),
      .up_itag_a_i  (up_itag_a_s[gi]),
      .up_itag_b_i  (up_itag_b_s[gi]),
      .up_dat_i     (up_dat_s[gi]),
      .wkn_flg_o    (wkn_flg_s[gi]),
      .itag_a_o     (itag_a_s[gi]),
      .itag_b_o     (itag_b_s[gi]),
      .dat_o        (dat_s[gi]),
      .cond_o       (cond_s[gi])
    );
  end

  // Oldest-ready select. mask_s marks the selected entry and everything above it.
  always_comb begin
    logic seen_v;
    seen_v    = 1'b0;
    sel_dat_s = '0;
    mask_s    = '0;
    for (int i = 0; i < N; i++) begin
      sel_dat_s = sel_dat_s | (dat_s[i] & {q_dat_width_g{cond_s[i] & ~seen_v}});
      seen_v    = seen_v | cond_s[i];
      mask_s[i] = seen_v;
    end
    any_rdy_s = seen_v;
  end

  // Issue, allocation and collapse controls.
  always_comb begin
    iss_en_s    = any_rdy_s & (~iss_vld_q | iss_take);
    alloc_s     = in_vld & ~full_q;
    alloc_idx_s = cnt_q - {{(CW-1){1'b0}}, iss_en_s};
    shift_s     = mask_s & {N{iss_en_s}};
    for (int i = 0; i < N; i++) begin
      load_s[i] = alloc_s & (alloc_idx_s == CW'(i));
    end
    // A wakeup that coincides with allocation marks the new source ready.
    new_flg_s.vld   = 1'b1;
    new_flg_s.rdy_a = in_rdy_a | (wk_vld & (wk_itag == in_itag_a));
    new_flg_s.rdy_b = in_rdy_b | (wk_vld & (wk_itag == in_itag_b));
  end

  // Next count, full flag and issue-stage contents.
  always_comb begin
    cnt_d     = cnt_q;
    iss_vld_d = iss_vld_q;
    iss_dat_d = iss_dat_q;
    if (flush) begin
      cnt_d     = '0;
      iss_vld_d = 1'b0;
    end else begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, alloc_s} - {{(CW-1){1'b0}}, iss_en_s};
      if (iss_en_s) begin
        iss_vld_d = 1'b1;
        iss_dat_d = sel_dat_s;
      end else if (iss_take) begin
        iss_vld_d = 1'b0;
      end else begin
        iss_vld_d = iss_vld_q;
      end
    end
    full_d = (cnt_d == CW'(N));
  end

  // Count, full flag and issue-stage registers. Reset takes priority over flush.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      cnt_q     <= '0;
      full_q    <= 1'b0;
      iss_vld_q <= 1'b0;
      iss_dat_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      full_q    <= full_d;
      iss_vld_q <= iss_vld_d;
      iss_dat_q <= iss_dat_d;
    end
  end

  assign in_full = full_q;
  assign q_cnt   = cnt_q;
  assign iss_vld = iss_vld_q;
  assign iss_dat = iss_dat_q;

endmodule

// File: tb/tb_rv_issue_q.sv
// Bench for rv_issue_q: an age-ordered queue model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_rv_issue_q;

  localparam int N  = 16;
  localparam int DW = 7;
  localparam int IW = 7;
  localparam int CW = 5;

  logic          clk;
  logic          rst_b;
  logic          flush;
  logic          in_vld;
  logic [IW-1:0] in_itag_a;
  logic [IW-1:0] in_itag_b;
  logic          in_rdy_a;
  logic          in_rdy_b;
  logic [DW-1:0] in_dat;
  logic          in_full;
  logic          wk_vld;
  logic [IW-1:0] wk_itag;
  logic          iss_vld;
  logic [DW-1:0] iss_dat;
  logic          iss_take;
  logic [CW-1:0] q_cnt;

  rv_issue_q #(
    .q_num_entries_g (N),
    .q_dat_width_g   (DW),
    .q_itag_width_g  (IW)
  ) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .flush     (flush),
    .in_vld    (in_vld),
    .in_itag_a (in_itag_a),
    .in_itag_b (in_itag_b),
    .in_rdy_a  (in_rdy_a),
    .in_rdy_b  (in_rdy_b),
    .in_dat    (in_dat),
    .in_full   (in_full),
    .wk_vld    (wk_vld),
    .wk_itag   (wk_itag),
    .iss_vld   (iss_vld),
    .iss_dat   (iss_dat),
    .iss_take  (iss_take),
    .q_cnt     (q_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a list of waiting instructions ordered oldest first.
  typedef struct {
    logic [IW-1:0] ia;
    logic [IW-1:0] ib;
    bit            ra;
    bit            rb;
    logic [DW-1:0] dat;
  } m_ent_t;

  m_ent_t        mq[$];
  bit            m_iv = 1'b0;
  logic [DW-1:0] m_id = '0;

  task automatic model_step();
    int     s;
    bit     en;
    bit     full;
    m_ent_t ne;
    if (!rst_b) begin
      mq.delete();
      m_iv = 1'b0;
      m_id = '0;
    end else if (flush) begin
      mq.delete();
      m_iv = 1'b0;
    end else begin
      full = (mq.size() == N);
      s = -1;
      foreach (mq[i]) if (s < 0 && mq[i].ra && mq[i].rb) s = i;
      en = (s >= 0) && (!m_iv || iss_take);
      if (wk_vld) begin
        foreach (mq[i]) begin
          if (mq[i].ia == wk_itag) mq[i].ra = 1'b1;
          if (mq[i].ib == wk_itag) mq[i].rb = 1'b1;
        end
      end
      if (en) begin
        m_id = mq[s].dat;
        mq.delete(s);
        m_iv = 1'b1;
      end else if (iss_take) begin
        m_iv = 1'b0;
      end
      if (in_vld && !full) begin
        ne.ia  = in_itag_a;
        ne.ib  = in_itag_b;
        ne.ra  = in_rdy_a || (wk_vld && wk_itag == in_itag_a);
        ne.rb  = in_rdy_b || (wk_vld && wk_itag == in_itag_b);
        ne.dat = in_dat;
        mq.push_back(ne);
      end
    end
  endtask

  // Compare DUT outputs against the model mid-cycle, then advance the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("m_iss_vld", {31'd0, iss_vld}, {31'd0, m_iv});
        chk("m_q_cnt", {27'd0, q_cnt}, mq.size());
        chk("m_in_full", {31'd0, in_full}, {31'd0, (mq.size() == N)});
        if (m_iv) chk("m_iss_dat", {25'd0, iss_dat}, {25'd0, m_id});
      end
      model_step();
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drv_alloc(input logic [IW-1:0] ia, input logic ra,
                           input logic [IW-1:0] ib, input logic rb,
                           input logic [DW-1:0] d);
    in_vld    = 1'b1;
    in_itag_a = ia;
    in_rdy_a  = ra;
    in_itag_b = ib;
    in_rdy_b  = rb;
    in_dat    = d;
  endtask

  initial begin
    rst_b = 1'b0; flush = 1'b0; in_vld = 1'b1;
    in_itag_a = '0; in_itag_b = '0; in_rdy_a = 1'b1; in_rdy_b = 1'b1;
    in_dat = 7'h5A; wk_vld = 1'b0; wk_itag = '0; iss_take = 1'b1;

    // Reset held two cycles with an allocate request pending.
    step(2);
    rst_b = 1'b1; in_vld = 1'b0;
    chk_en = 1'b1;
    chk("rst_iss_vld", {31'd0, iss_vld}, 32'd0);
    chk("rst_iss_dat", {25'd0, iss_dat}, 32'd0);
    chk("rst_q_cnt", {27'd0, q_cnt}, 32'd0);
    chk("rst_in_full", {31'd0, in_full}, 32'd0);
    step(1);
    chk("rst_idle_cnt", {27'd0, q_cnt}, 32'd0);

    // Ready allocation reaches the issue stage two cycles later.
    drv_alloc(7'h01, 1'b1, 7'h02, 1'b1, 7'h2A);
    step(1);
    in_vld = 1'b0;
    chk("rdy_t1_vld", {31'd0, iss_vld}, 32'd0);
    chk("rdy_t1_cnt", {27'd0, q_cnt}, 32'd1);
    step(1);
    chk("rdy_t2_vld", {31'd0, iss_vld}, 32'd1);
    chk("rdy_t2_dat", {25'd0, iss_dat}, 32'h2A);
    chk("rdy_t2_cnt", {27'd0, q_cnt}, 32'd0);
    step(2);

    // Age order and compaction: A(waits on 0x05), B(ready), C(waits on 0x09).
    drv_alloc(7'h05, 1'b0, 7'h00, 1'b1, 7'h11);
    step(1);
    drv_alloc(7'h06, 1'b1, 7'h00, 1'b1, 7'h22);
    step(1);
    drv_alloc(7'h09, 1'b0, 7'h00, 1'b1, 7'h33);
    step(1);
    in_vld = 1'b0;
    chk("age_b_vld", {31'd0, iss_vld}, 32'd1);
    chk("age_b_dat", {25'd0, iss_dat}, 32'h22);
    chk("age_b_cnt", {27'd0, q_cnt}, 32'd2);
    wk_vld = 1'b1; wk_itag = 7'h05;
    step(1);
    wk_vld = 1'b0;
    chk("age_gap_vld", {31'd0, iss_vld}, 32'd0);
    step(1);
    chk("age_a_vld", {31'd0, iss_vld}, 32'd1);
    chk("age_a_dat", {25'd0, iss_dat}, 32'h11);
    chk("age_a_cnt", {27'd0, q_cnt}, 32'd1);
    wk_vld = 1'b1; wk_itag = 7'h09;
    step(1);
    wk_vld = 1'b0;
    step(3);
    chk("age_drain_cnt", {27'd0, q_cnt}, 32'd0);

    // Backpressure: the oldest payload is held while take is low.
    iss_take = 1'b0;
    drv_alloc(7'h20, 1'b1, 7'h21, 1'b1, 7'h41);
    step(1);
    drv_alloc(7'h20, 1'b1, 7'h21, 1'b1, 7'h42);
    step(1);
    drv_alloc(7'h20, 1'b1, 7'h21, 1'b1, 7'h43);
    step(1);
    in_vld = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("bp_hold_dat", {25'd0, iss_dat}, 32'h41);
      chk("bp_hold_cnt", {27'd0, q_cnt}, 32'd2);
      step(1);
    end
    iss_take = 1'b1;
    step(1);
    chk("bp_second", {25'd0, iss_dat}, 32'h42);
    step(1);
    chk("bp_third", {25'd0, iss_dat}, 32'h43);
    chk("bp_third_cnt", {27'd0, q_cnt}, 32'd0);
    step(1);
    chk("bp_empty_vld", {31'd0, iss_vld}, 32'd0);

    // Full boundary: sixteen unready entries, extra requests are dropped.
    for (int k = 0; k < N; k++) begin
      drv_alloc(7'h10 + 7'(k), 1'b0, 7'h00, 1'b1, 7'(k));
      step(1);
    end
    chk("full_cnt", {27'd0, q_cnt}, 32'd16);
    chk("full_flag", {31'd0, in_full}, 32'd1);
    drv_alloc(7'h7F, 1'b0, 7'h00, 1'b1, 7'h7F);
    step(2);
    chk("full_drop_cnt", {27'd0, q_cnt}, 32'd16);
    drv_alloc(7'h60, 1'b0, 7'h00, 1'b1, 7'h55);
    wk_vld = 1'b1; wk_itag = 7'h17;
    step(1);
    wk_vld = 1'b0;
    chk("full_wk_cnt", {27'd0, q_cnt}, 32'd16);
    chk("full_wk_flag", {31'd0, in_full}, 32'd1);
    step(1);
    chk("full_iss_cnt", {27'd0, q_cnt}, 32'd15);
    chk("full_iss_flag", {31'd0, in_full}, 32'd0);
    chk("full_iss_dat", {25'd0, iss_dat}, 32'd7);
    step(1);
    in_vld = 1'b0;
    chk("full_refill_cnt", {27'd0, q_cnt}, 32'd16);
    chk("full_refill_flag", {31'd0, in_full}, 32'd1);

    // Drain six, leaving ten entries, then flush with coincident traffic.
    for (int k = 0; k < 6; k++) begin
      wk_vld = 1'b1; wk_itag = 7'h10 + 7'(k);
      step(1);
    end
    wk_vld = 1'b0;
    step(3);
    chk("pre_flush_cnt", {27'd0, q_cnt}, 32'd10);
    wk_vld = 1'b1; wk_itag = 7'h18;
    step(1);
    flush = 1'b1; wk_itag = 7'h19;
    drv_alloc(7'h02, 1'b1, 7'h03, 1'b1, 7'h77);
    step(1);
    flush = 1'b0; wk_vld = 1'b0; in_vld = 1'b0;
    chk("flush_cnt", {27'd0, q_cnt}, 32'd0);
    chk("flush_vld", {31'd0, iss_vld}, 32'd0);
    step(4);
    chk("flush_quiet", {31'd0, iss_vld}, 32'd0);

    // Reset mid-stream with take asserted.
    iss_take = 1'b0;
    drv_alloc(7'h30, 1'b1, 7'h31, 1'b1, 7'h61);
    step(1);
    drv_alloc(7'h30, 1'b1, 7'h31, 1'b1, 7'h62);
    step(1);
    in_vld = 1'b0; rst_b = 1'b0; iss_take = 1'b1;
    step(1);
    rst_b = 1'b1;
    chk("mrst_cnt", {27'd0, q_cnt}, 32'd0);
    chk("mrst_vld", {31'd0, iss_vld}, 32'd0);
    chk("mrst_dat", {25'd0, iss_dat}, 32'd0);
    step(1);

    // Back-to-back ready allocations issue one per cycle.
    for (int k = 0; k < 8; k++) begin
      drv_alloc(7'h40, 1'b1, 7'h41, 1'b1, 7'h30 + 7'(k));
      step(1);
    end
    in_vld = 1'b0;
    chk("tput_dat", {25'd0, iss_dat}, 32'h36);
    chk("tput_cnt", {27'd0, q_cnt}, 32'd1);
    step(4);
    chk("tput_end_cnt", {27'd0, q_cnt}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
